// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state enum, the counter-width helper and the default width.
package seq_mult_pkg;

    localparam int SEQ_MULT_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } seq_mult_state_t;

    // Bits needed to count 0..w inclusive.
    function automatic int seq_mult_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/param_signed_seq_mult_negate.sv
// Conditional two's-complement negate of a W-bit value.
// Ports: en (negate when 1), a (value in), y (a or -a).
module twos_negate #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = en ? ((~a) + W'(1)) : a;

endmodule

// File: rtl/param_signed_seq_mult.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
// Ports: clk, rst_n (async low); start, signed_mode, multiplier,
//   multiplicand (sampled in IDLE); product (2*WIDTH), busy, done, neg.
// Optional macro SEQ_MULT_EARLY_EXIT_EN: CALC stops once the remaining
//   multiplier magnitude is zero; results are unchanged, latency shrinks.
module param_signed_seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = SEQ_MULT_DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done,
    output logic               neg
);

    localparam int CW = seq_mult_cnt_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    seq_mult_state_t state, state_nxt;

    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] mag_a, mag_a_nxt;
    logic [PW-1:0]    mag_b, mag_b_nxt;
    logic [PW-1:0]    acc, acc_nxt;
    logic             sign_r, sign_nxt;
    logic             smode_r, smode_nxt;
    logic [PW-1:0]    prod_r, prod_nxt;
    logic             neg_r, neg_nxt;

    logic [WIDTH-1:0] op_a_mag;
    logic [WIDTH-1:0] op_b_mag;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    prod_fix;
    logic             last;
    logic             opnd_sign;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1).
    twos_negate #(.W(WIDTH)) u_neg_a (
        .en (signed_mode & multiplier[WIDTH-1]),
        .a  (multiplier),
        .y  (op_a_mag)
    );

    twos_negate #(.W(WIDTH)) u_neg_b (
        .en (signed_mode & multiplicand[WIDTH-1]),
        .a  (multiplicand),
        .y  (op_b_mag)
    );

    assign addend   = mag_a[0] ? mag_b : '0;
    assign acc_step = acc + addend;

    // Sign is applied to the final accumulator value as CALC completes.
    twos_negate #(.W(PW)) u_neg_p (
        .en (sign_r),
        .a  (acc_step),
        .y  (prod_fix)
    );

    // A zero operand forces a positive result so -0 never appears.
    assign opnd_sign = signed_mode
                     & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1])
                     & (|multiplier)
                     & (|multiplicand);

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign last = (cnt == CW'(WIDTH - 1))
                | (mag_a[WIDTH-1:1] == '0);
`else
    assign last = (cnt == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mag_a_nxt = mag_a;
        mag_b_nxt = mag_b;
        acc_nxt   = acc;
        sign_nxt  = sign_r;
        smode_nxt = smode_r;
        prod_nxt  = prod_r;
        neg_nxt   = neg_r;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                    cnt_nxt   = '0;
                    mag_a_nxt = op_a_mag;
                    mag_b_nxt = {{WIDTH{1'b0}}, op_b_mag};
                    acc_nxt   = '0;
                    sign_nxt  = opnd_sign;
                    smode_nxt = signed_mode;
                end
            end
            CALC: begin
                acc_nxt   = acc_step;
                mag_a_nxt = mag_a >> 1;
                mag_b_nxt = mag_b << 1;
                cnt_nxt   = cnt + CW'(1);
                if (last) begin
                    state_nxt = DONE;
                    prod_nxt  = prod_fix;
                    neg_nxt   = smode_r & prod_fix[PW-1];
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            sign_r  <= 1'b0;
            smode_r <= 1'b0;
            prod_r  <= '0;
            neg_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mag_a   <= mag_a_nxt;
            mag_b   <= mag_b_nxt;
            acc     <= acc_nxt;
            sign_r  <= sign_nxt;
            smode_r <= smode_nxt;
            prod_r  <= prod_nxt;
            neg_r   <= neg_nxt;
        end
    end

    assign product = prod_r;
    assign neg     = neg_r;
    assign done    = (state == DONE);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_param_signed_seq_mult.sv
// Scoreboard bench for param_signed_seq_mult (WIDTH=8).
// Driver pushes expected results; a monitor pops and checks on done.
module tb_param_signed_seq_mult;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  multiplier;
    logic [W-1:0]  multiplicand;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;
    logic          neg;

    param_signed_seq_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .neg          (neg)
    );

    typedef struct {
        logic [PW-1:0] p;
        logic          ng;
        int            lat;
        int            t;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer product; latency from the magnitude's MSB.
    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic s);
        exp_t        e;
        longint      av, bv, pr, mag;
        logic [63:0] t;
        int          n;
        av = s ? longint'($signed(a)) : longint'(a);
        bv = s ? longint'($signed(b)) : longint'(b);
        pr = av * bv;
        t  = pr;
        e.p  = t[PW-1:0];
        e.ng = s && (pr < 0);
        mag = (av < 0) ? -av : av;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < W; i++)
            if (mag[i]) n = i + 1;
`else
        n = W;
`endif
        e.lat = n + 1;
        e.t   = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", 64'(product), 64'(e.p));
                check("neg", 64'(neg), 64'(e.ng));
                check("latency", 64'(cyc - e.t + 1), 64'(e.lat));
                check("busy_at_done", 64'(busy), 64'(1));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic s,
                         input logic hold,
                         input logic noisy);
        exp_t e;
        int   g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
        start        = 1'b1;
        signed_mode  = s;
        multiplier   = a;
        multiplicand = b;
        @(posedge clk);
        #1;
        e   = model(a, b, s);
        e.t = cyc;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (noisy) begin
            while (busy) begin
                start        = 1'b1;
                signed_mode  = 1'($urandom);
                multiplier   = W'($urandom);
                multiplicand = W'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
        end
    endtask

    logic [W-1:0] da [8] = '{8'h80, 8'hFB, 8'hFB, 8'h00,
                             8'hFF, 8'h80, 8'h7F, 8'h01};
    logic [W-1:0] db [8] = '{8'h80, 8'h07, 8'h07, 8'hFD,
                             8'hFF, 8'h7F, 8'h80, 8'hFF};
    logic         ds [8] = '{1'b1, 1'b1, 1'b0, 1'b1,
                             1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int g;
        rst_n        = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_product", 64'(product), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_neg", 64'(neg), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            issue(da[i], db[i], ds[i], 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            issue(W'($urandom), W'($urandom), 1'($urandom),
                  1'b0, ($urandom_range(0, 3) == 0));

        issue(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++)
            issue(W'($urandom), W'($urandom), 1'($urandom),
                  1'b1, 1'b0);
        start = 1'b0;

        // Abort an operation partway through CALC.
        issue(8'h80, 8'h55, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_product", 64'(product), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_neg", 64'(neg), 64'(0));
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'hFD, 8'h06, 1'b1, 1'b0, 1'b0);

        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0)
            check("drain_timeout", 64'(sb.size()), 64'(0));
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
